// File: rtl/sel_debounce_toggle.sv
// Pushbutton debouncer that flips a registered 2:1 mux select once per accepted press.
// Optional auto-alternate mode (auto_en port, periodic flips) is enabled by defining SEL_AUTO_TOGGLE_EN.
module sel_debounce_toggle #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit INIT_SEL        = 1'b0,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
`ifdef SEL_AUTO_TOGGLE_EN
    input  logic auto_en,
`endif
    output logic sel,
    output logic toggle
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || AUTO_PERIOD < 2) begin : g_param_check
        $error("sel_debounce_toggle: parameter out of legal range");
    end

    logic          sync1;
    logic          btn_s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_flip;
    logic          flip;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
        end
    end

    // Debounce FSM next-state; a press is accepted only once per full press/release cycle
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        press_flip = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt < CNT_MAX) begin
                    cnt_nxt   = cnt + CW'(1);
                end else begin
                    state_nxt  = HELD;
                    cnt_nxt    = '0;
                    press_flip = 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CW'(1);
                end else begin
                    state_nxt = HELD;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high while releasing is absorbed without a flip
                if (btn_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt < CNT_MAX) begin
                    cnt_nxt   = cnt + CW'(1);
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef SEL_AUTO_TOGGLE_EN
    localparam int AW = $clog2(AUTO_PERIOD);
    localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_PERIOD - 1);

    logic [AW-1:0] auto_cnt;
    logic [AW-1:0] auto_cnt_nxt;
    logic          auto_wrap;

    // Auto-alternate period counter; an accepted press merges with a wrap and restarts the period
    always_comb begin
        auto_wrap    = 1'b0;
        auto_cnt_nxt = auto_cnt;
        if (!auto_en) begin
            auto_cnt_nxt = '0;
        end else if (auto_cnt == AUTO_MAX) begin
            auto_wrap    = 1'b1;
            auto_cnt_nxt = '0;
        end else if (press_flip) begin
            auto_cnt_nxt = '0;
        end else begin
            auto_cnt_nxt = auto_cnt + AW'(1);
        end
        flip = press_flip | auto_wrap;
    end

    // Auto counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt_nxt;
        end
    end
`else
    assign flip = press_flip;
`endif

    // FSM state, debounce counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= INIT_SEL;
            toggle <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sel    <= sel ^ flip;
            toggle <= flip;
        end
    end

endmodule
